// File: rtl/music_score_player.sv
// Score ROM sequencer and square-wave buzzer driver.
// Steps a beat-rate address through a combinational score ROM. Each 12-bit
// word {high, med, low} is decoded into one note, and the buzzer toggles at
// that note's pitch.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start, stop     one-cycle command pulses (stop wins)
//   pause           level; freezes beat progress and silences the buzzer
//   loop_en         level; wrap to address 0 at end of score
//   rom_addr        registered score ROM address
//   rom_data        combinational ROM read data for rom_addr
//   buzzer          square-wave tone output, 0 when silent
//   playing, done   play status; done pulses once when a non-looping score ends
//   cur_note        decoded note (0 = rest, 1-7 = do-ti)
//   cur_octave      decoded octave (0 = rest, 1 = low, 2 = med, 3 = high)
module music_score_player #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BEAT_TICKS = 12_500_000,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned ROM_WIDTH  = 12,
  parameter int unsigned SCORE_LEN  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  loop_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]  rom_data,
  output logic                  buzzer,
  output logic                  playing,
  output logic                  done,
  output logic [3:0]            cur_note,
  output logic [1:0]            cur_octave
);

  // Longest half-period belongs to the lowest pitch (262 Hz, octave 1).
  localparam int unsigned HALF_MAX = CLK_FREQ / 524;
  localparam int unsigned TONE_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int unsigned BEAT_W   = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;

  localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BEAT_TICKS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(SCORE_LEN - 1);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  typedef struct packed {
    logic [3:0] note;
    logic [1:0] oct;
  } note_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [TONE_W-1:0]     tone_q, tone_d;
  logic [ROM_WIDTH-1:0]  word_q, word_d;
  logic                  buzz_q, buzz_d;
  logic                  playing_q, playing_d;
  logic                  done_q, done_d;
  note_t                 note_cur, note_new;
  logic [TONE_W-1:0]     half_m1;

  // Half-period minus one for (octave, note); zero for any rest slot.
  function automatic int unsigned half_calc(input int unsigned o, input int unsigned n);
    int unsigned f;
    int unsigned h;
    case (n)
      1:       f = 262;
      2:       f = 294;
      3:       f = 330;
      4:       f = 349;
      5:       f = 392;
      6:       f = 440;
      7:       f = 494;
      default: f = 0;
    endcase
    if (o == 0) f = 0;
    else        f = f << (o - 1);
    if (f == 0) return 0;
    h = CLK_FREQ / (2 * f);
    return (h > 0) ? h - 1 : 0;
  endfunction

  // Highest non-zero nibble wins; a winning nibble of 8-F is a rest.
  function automatic note_t decode(input logic [11:0] w);
    logic [3:0] nib;
    logic [1:0] oct;
    if (w[11:8] != 4'd0) begin
      nib = w[11:8];
      oct = 2'd3;
    end else if (w[7:4] != 4'd0) begin
      nib = w[7:4];
      oct = 2'd2;
    end else if (w[3:0] != 4'd0) begin
      nib = w[3:0];
      oct = 2'd1;
    end else begin
      nib = 4'd0;
      oct = 2'd0;
    end
    if (nib[3]) begin
      nib = 4'd0;
      oct = 2'd0;
    end
    decode.note = nib;
    decode.oct  = oct;
  endfunction

  // Constant pitch table indexed by {octave, note[2:0]}.
  logic [TONE_W-1:0] half_tab [32];
  for (genvar gi = 0; gi < 32; gi++) begin : g_half
    assign half_tab[gi] = TONE_W'(half_calc(gi / 8, gi % 8));
  end

  assign note_cur = decode(word_q[11:0]);
  assign note_new = decode(word_d[11:0]);
  assign half_m1  = half_tab[{note_cur.oct, note_cur.note[2:0]}];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      beat_q    <= '0;
      tone_q    <= '0;
      word_q    <= '0;
      buzz_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      cur_note  <= 4'd0;
      cur_octave <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      tone_q    <= tone_d;
      word_q    <= word_d;
      buzz_q    <= buzz_d;
      playing_q <= playing_d;
      done_q    <= done_d;
      cur_note  <= note_new.note;
      cur_octave <= note_new.oct;
    end
  end

  // Next-state: commands, beat sequencing, then the tone generator.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    tone_d    = tone_q;
    word_d    = word_q;
    buzz_d    = buzz_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        word_d = '0;
        if (start) begin
          state_d = PLAY;
          addr_d  = '0;
          beat_d  = '0;
        end
      end
      PLAY: begin
        word_d = rom_data;
        if (stop) begin
          state_d = IDLE;
          addr_d  = '0;
          beat_d  = '0;
          word_d  = '0;
        end else if (start) begin
          addr_d = '0;
          beat_d = '0;
        end else if (!pause) begin
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            if (addr_q < ADDR_LAST) begin
              addr_d = addr_q + ADDR_WIDTH'(1);
            end else if (loop_en) begin
              addr_d = '0;
            end else begin
              state_d = IDLE;
              addr_d  = '0;
              word_d  = '0;
              done_d  = 1'b1;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new note restarts phase-aligned low; rests and pause stay silent.
    if (state_d != PLAY || pause || note_new != note_cur || note_cur.note == 4'd0) begin
      tone_d = '0;
      buzz_d = 1'b0;
    end else if (tone_q == half_m1) begin
      tone_d = '0;
      buzz_d = ~buzz_q;
    end else begin
      tone_d = tone_q + TONE_W'(1);
    end

    playing_d = (state_d == PLAY);
  end

  assign rom_addr = addr_q;
  assign buzzer   = buzz_q;
  assign playing  = playing_q;
  assign done     = done_q;

endmodule

// File: doc/music_score_player.md
Name: music_score_player

Overview:
- Reader/sequencer for the buzzer score ROMs.
- Drives a beat-rate address into a combinational score ROM and decodes each 12-bit word {high[3:0], med[3:0], low[3:0]} into one note.
- Produces a square-wave buzzer output at that note's pitch, plus play status for LEDs and the display.
- Sits between the top-level control (buttons/switches) and the buzzer pin.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz; tone half-periods are derived from it.
BEAT_TICKS, 12_500_000, clock cycles per ROM entry (one beat slot).
ADDR_WIDTH, 7, ROM address width.
ROM_WIDTH, 12, ROM word width.
SCORE_LEN, 128, number of ROM entries played; last address is SCORE_LEN-1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin or restart playback from address 0
stop  in  1  one-cycle pulse; abort playback
pause  in  1  level; freeze beat progress and silence the buzzer while high
loop_en  in  1  level; at end of score wrap to address 0 instead of finishing
rom_addr  out  ADDR_WIDTH  registered address to the score ROM
rom_data  in  ROM_WIDTH  combinational ROM read data for rom_addr
buzzer  out  1  square-wave tone output; 0 when silent
playing  out  1  high while in the PLAY state
done  out  1  one-cycle pulse when a non-looping score completes
cur_note  out  4  registered decoded note: 0 = rest, 1-7 = do-ti
cur_octave  out  2  0 = rest, 1 = low, 2 = med, 3 = high

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - rom_addr, beat_cnt, tone_cnt, cur_word = 0.
  - buzzer, playing, done = 0; cur_note = 0; cur_octave = 0.
- FSM: IDLE, PLAY.
- IDLE:
  - buzzer=0 and cur_word held at 0.
  - start → PLAY next cycle with rom_addr=0 and beat_cnt=0.
- PLAY:
  - When pause=0, beat_cnt increments each cycle.
  - At beat_cnt==BEAT_TICKS-1: beat_cnt←0.
    - If rom_addr<SCORE_LEN-1: rom_addr←rom_addr+1.
    - Else if loop_en=1: rom_addr←0.
    - Else: state←IDLE, rom_addr←0, done=1 for exactly one cycle.
  - pause=1: beat_cnt and rom_addr hold; tone_cnt←0; buzzer←0.
- Command priority:
  - stop in PLAY → IDLE next cycle (no done pulse); stop wins over a simultaneous start.
  - start in PLAY (no stop) → restart at rom_addr=0, beat_cnt=0.
  - stop in IDLE is ignored.
- Decode: cur_word←rom_data every cycle in PLAY (1-cycle latency from rom_addr). The highest non-zero field wins:
  - high≠0 → octave 3.
  - else med≠0 → octave 2.
  - else low≠0 → octave 1.
  - else rest.
  - A winning nibble of 8-F is treated as a rest (cur_note=0, cur_octave=0).
- Pitch:
  - Base frequencies in Hz for notes 1-7: 262, 294, 330, 349, 392, 440, 494.
  - Octave 1 uses the base; octave 2 uses ×2; octave 3 uses ×4.
  - half = CLK_FREQ / (2·freq), integer division, constant table.
- Tone generator:
  - On a rest: tone_cnt=0 and buzzer=0.
  - On a note: tone_cnt counts 0..half-1; at half-1 it resets to 0 and buzzer toggles.
  - Whenever the decoded (note, octave) changes, tone_cnt←0 and buzzer←0 that cycle, so every new note starts phase-aligned low.
  - Consecutive beats with an identical note do not retrigger.
- Width rule: tone_cnt and beat_cnt are wide enough for the largest half-period and BEAT_TICKS-1 respectively; no truncation.
- playing = (state==PLAY), registered.

Test Plan:
- Reset mid-play:
  - Stimulus: CLK_FREQ=880_000, BEAT_TICKS=4000; start; play 3 beats; assert rst for 1 cycle.
  - Required: next cycle rom_addr=0, buzzer=0, playing=0, cur_note=0; start alone is then needed to resume.
- Tone pitch:
  - Stimulus: ROM model word {0,0,6} at all addresses, CLK_FREQ=880_000, BEAT_TICKS large.
  - Required: cur_note=6, cur_octave=1; buzzer toggles every 1000 cycles (A4 half=1000).
  - Stimulus: same setup with word {0,6,0}.
  - Required: toggles every 500 cycles.
- Priority and rest decode:
  - Stimulus: word {3,5,1}.
  - Required: cur_note=3, cur_octave=3.
  - Stimulus: word {0,0,0} or {0,0,9}.
  - Required: buzzer constantly 0, cur_note=0.
- Sequencing and done:
  - Stimulus: BEAT_TICKS=16, SCORE_LEN=128, loop_en=0, start.
  - Required: rom_addr steps 0→127 every 16 cycles; after the last beat, one-cycle done=1, playing=0, rom_addr=0.
  - Stimulus: same with loop_en=1.
  - Required: wraps 127→0, no done pulse, playing stays 1.
- Pause and stop:
  - Stimulus: pause high for 50 cycles at rom_addr=5.
  - Required: rom_addr=5 and beat_cnt frozen, buzzer=0; progress resumes where it left off on release.
  - Stimulus: stop and start in the same cycle.
  - Required: IDLE, no done.
- Restart:
  - Stimulus: start pulse while at rom_addr=40 in PLAY.
  - Required: next cycle rom_addr=0, beat_cnt=0, playing stays 1.
